memory: RTL and testbench

MEMORY -- requirements
Module: memory

---
 rtl/memory_pkg.sv | 12 +
 rtl/memory_array.sv | 38 +++
 rtl/memory.sv | 62 ++++++
 tb/tb_memory.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/memory_pkg.sv
// Shared constants and word/address types for the memory block.
// Default geometry is a 4-word by 8-bit register file.
package memory_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 2;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

  typedef logic [DEFAULT_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/memory_array.sv
// Storage for the memory block: register array with one write port, a
// combinational read port and asynchronous clear of every word.
module memory_array
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rd_word
);

  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  in_range;

  // Addresses at or beyond DEPTH are not backed by storage.
  assign in_range = ({1'b0, addr} < DEPTH_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && in_range) begin
      mem[addr] <= wdata;
    end
  end

  assign rd_word = in_range ? mem[addr] : '0;

endmodule

// File: rtl/memory.sv
// Single-port memory with a registered read (latency 1). Define MEM_BYPASS_EN
// for write-first forwarding on a same-cycle write and read; otherwise read-first.
module memory
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] stored_word;
  logic [DATA_WIDTH-1:0] next_rdata;

  memory_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wr_en  (wr_en),
    .wdata  (wdata),
    .rd_word(stored_word)
  );

`ifdef MEM_BYPASS_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(DEPTH);

  logic addr_valid;
  assign addr_valid = ({1'b0, addr} < DEPTH_LIMIT);

  // Forward only writes that actually land in storage.
  always_comb begin
    next_rdata = stored_word;
    if (wr_en && addr_valid) begin
      next_rdata = wdata;
    end
  end
`else
  always_comb begin
    next_rdata = stored_word;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= next_rdata;
    end
  end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for memory: directed scenarios plus randomized traffic
// compared against a simple array model; honours MEM_BYPASS_EN when defined.
module tb_memory;

  localparam int AW    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] model_rdata;

`ifdef MEM_BYPASS_EN
  bit bypass = 1'b1;
`else
  bit bypass = 1'b0;
`endif

  memory #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wdata(wdata),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic check_output(string tag, logic [DW-1:0] observed, logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: rdata=0x%02h expected=0x%02h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rdata = '0;
  endtask

  // One clock of traffic; the model is advanced with the values held across the edge.
  task automatic apply_stimulus(bit w, bit r, logic [AW-1:0] a, logic [DW-1:0] d);
    wr_en = w;
    rd_en = r;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    if (r) model_rdata = (bypass && w) ? d : model_mem[a];
    if (w) model_mem[a] = d;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  // Reset raised between edges with strobes active, held over one edge, then released.
  task automatic async_reset(logic [AW-1:0] a, logic [DW-1:0] d);
    #2;
    reset = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    addr  = a;
    wdata = d;
    #1;
    check_output("reset_immediate", rdata, 8'h00);
    @(posedge clk);
    #1;
    check_output("reset_held", rdata, 8'h00);
    wr_en = 1'b0;
    rd_en = 1'b0;
    reset = 1'b0;
    clear_model();
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr  = '0;
    wdata = '0;
    clear_model();
    #1;
    check_output("reset_state", rdata, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b1, AW'(i), 8'h00);
      check_output("default_read", rdata, 8'h00);
    end

    apply_stimulus(1'b1, 1'b0, 2'd1, 8'hA5);
    apply_stimulus(1'b1, 1'b0, 2'd2, 8'h3C);
    apply_stimulus(1'b0, 1'b1, 2'd1, 8'h00);
    check_output("read_a5", rdata, 8'hA5);
    apply_stimulus(1'b0, 1'b1, 2'd2, 8'h00);
    check_output("read_3c", rdata, 8'h3C);

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 2'd2, 8'h99);
      check_output("hold", rdata, 8'h3C);
    end
    apply_stimulus(1'b0, 1'b1, 2'd2, 8'h00);
    check_output("read_99", rdata, 8'h99);

    apply_stimulus(1'b1, 1'b0, 2'd3, 8'h11);
    apply_stimulus(1'b1, 1'b1, 2'd3, 8'h77);
    check_output("same_addr_rw", rdata, bypass ? 8'h77 : 8'h11);
    apply_stimulus(1'b0, 1'b1, 2'd3, 8'h00);
    check_output("same_addr_after", rdata, 8'h77);

    apply_stimulus(1'b1, 1'b0, 2'd0, 8'h5A);
    apply_stimulus(1'b0, 1'b1, 2'd0, 8'h00);
    check_output("read_5a", rdata, 8'h5A);
    apply_stimulus(1'b1, 1'b0, 2'd1, 8'hF0);
    check_output("read_5a_hold", rdata, 8'h5A);
    apply_stimulus(1'b0, 1'b1, 2'd1, 8'h00);
    check_output("read_f0", rdata, 8'hF0);

    apply_stimulus(1'b1, 1'b0, 2'd2, 8'hFF);
    apply_stimulus(1'b0, 1'b1, 2'd2, 8'h00);
    check_output("read_ff", rdata, 8'hFF);
    async_reset(2'd2, 8'hEE);
    apply_stimulus(1'b0, 1'b1, 2'd2, 8'h00);
    check_output("read_after_reset", rdata, 8'h00);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        async_reset(AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        check_output("random_reset", rdata, model_rdata);
      end else begin
        apply_stimulus(1'($urandom), 1'($urandom), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom));
        check_output("random", rdata, model_rdata);
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1'b0, 1'b1, AW'(i), 8'h00);
      check_output("final_sweep", rdata, model_mem[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
